cfi_violation_handler: RTL

- Sits directly downstream of the commit-stage CFI monitor.
- Captures each violation pulse with its class code and offending PC, and buffers it in a small FIFO for software or a debug module to drain.
- Keeps a saturating violation count and raises an interrupt.
- Raises a sticky halt request once a programmable threshold is reached.

---
 rtl/cfi_violation_handler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cfi_violation_handler.sv
// Captures CFI violation pulses into a small first-word-fall-through log FIFO.
// Also keeps a saturating violation count and raises an interrupt and a sticky halt request.
module cfi_violation_handler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PC_WIDTH   = 64,
    parameter int unsigned CODE_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  viol_valid_i,
    input  logic [CODE_WIDTH-1:0] viol_code_i,
    input  logic [PC_WIDTH-1:0]   viol_pc_i,
    input  logic [CNT_WIDTH-1:0]  threshold_i,
    input  logic                  clear_i,
    output logic                  log_valid_o,
    input  logic                  log_ready_i,
    output logic [CODE_WIDTH-1:0] log_code_o,
    output logic [PC_WIDTH-1:0]   log_pc_o,
    output logic [CNT_WIDTH-1:0]  viol_count_o,
    output logic                  overflow_o,
    output logic                  irq_o,
    output logic                  halt_req_o,
    output logic [1:0]            state_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StAlert = 2'b01,
        StHalt  = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic [CODE_WIDTH-1:0] code_mem_q [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem_q   [FIFO_DEPTH];
    logic [AW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
    logic                  overflow_q, overflow_d;
    logic                  halt_q, halt_d;
    logic                  irq_q;
    logic                  empty, full, push, pop, drop, halt_cond;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // clear_i masks every other action in its cycle
    assign pop  = ~clear_i & ~empty & log_ready_i;
    assign push = ~clear_i & viol_valid_i & (~full | pop);
    assign drop = ~clear_i & viol_valid_i & full & ~pop;

    assign cnt_inc   = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign halt_cond = ~clear_i & viol_valid_i & (threshold_i != '0) & (cnt_inc >= threshold_i);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q | drop;
        halt_d     = halt_q | halt_cond;
        state_d    = state_q;
        if (push) wptr_d = wptr_q + (AW+1)'(1);
        if (pop)  rptr_d = rptr_q + (AW+1)'(1);
        if (viol_valid_i) cnt_d = cnt_inc;
        if (clear_i) begin
            wptr_d     = '0;
            rptr_d     = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
            halt_d     = 1'b0;
            state_d    = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (halt_cond)   state_d = StHalt;
                    else if (push)   state_d = StAlert;
                end
                StAlert: begin
                    if (halt_cond) state_d = StHalt;
                    else if ((wptr_d == rptr_d) && !overflow_d) state_d = StIdle;
                end
                StHalt:  state_d = StHalt;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            halt_q     <= halt_d;
            irq_q      <= (state_d != StIdle);
        end
    end

    // Storage needs no reset; the head is masked to zero while empty
    always_ff @(posedge clk_i) begin
        if (push) begin
            code_mem_q[wptr_q[AW-1:0]] <= viol_code_i;
            pc_mem_q[wptr_q[AW-1:0]]   <= viol_pc_i;
        end
    end

    assign log_valid_o  = ~empty;
    assign log_code_o   = empty ? '0 : code_mem_q[rptr_q[AW-1:0]];
    assign log_pc_o     = empty ? '0 : pc_mem_q[rptr_q[AW-1:0]];
    assign viol_count_o = cnt_q;
    assign overflow_o   = overflow_q;
    assign halt_req_o   = halt_q;
    assign irq_o        = irq_q;
    assign state_o      = state_q;

endmodule
